// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks FIRST_REG..LAST_REG over a spare read port and streams each value with a running checksum.
// Two cycles per beat (READ then SEND); a beat is held stable in SEND until out_ready accepts it.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_rn,
  input  logic [31:0] rf_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  if (FIRST_REG > LAST_REG || FIRST_REG < 0 || LAST_REG > 31) begin : g_bad_range
    $error("regfile_dump_reader: FIRST_REG must be <= LAST_REG and both within 0..31");
  end

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t     state;
  logic [4:0] idx;

  assign rf_rn = idx;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      idx       <= FIRST;
      out_valid <= 1'b0;
      out_idx   <= 5'd0;
      out_data  <= 32'd0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      checksum  <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            idx      <= FIRST;
            checksum <= 32'd0;
            state    <= READ;
          end
        end
        READ: begin
          if (abort) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_data  <= rf_q;
            out_idx   <= idx;
            out_last  <= (idx == LAST);
            out_valid <= 1'b1;
            checksum  <= checksum + rf_q;
            state     <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // idx stops at LAST because out_last routes to DONE first
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: stimulus pushes expected beats per instance, negedge monitors pop on each accepted beat.
module tb_regfile_dump_reader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start0, abort0, out_ready0;
  logic        start1, abort1, out_ready1;
  logic [4:0]  rf_rn0, rf_rn1, out_idx0, out_idx1;
  logic [31:0] rf_q0, rf_q1, out_data0, out_data1, checksum0, checksum1;
  logic        out_valid0, out_valid1, out_last0, out_last1;
  logic        busy0, busy1, done0, done1;

  logic [31:0] rf [32];
  beat_t       q0[$];
  beat_t       q1[$];
  beat_t       e0, e1;
  logic [38:0] held0;
  logic        hold0 = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt0 = 0, done_cnt1 = 0;
  int          done_cyc0 = 0, done_cyc1 = 0;

  assign rf_q0 = (rf_rn0 == 5'd0) ? 32'd0 : rf[rf_rn0];
  assign rf_q1 = (rf_rn1 == 5'd0) ? 32'd0 : rf[rf_rn1];

  regfile_dump_reader u0 (
    .clk(clk), .clrn(clrn), .start(start0), .abort(abort0), .rf_rn(rf_rn0), .rf_q(rf_q0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_idx(out_idx0), .out_data(out_data0),
    .out_last(out_last0), .busy(busy0), .done(done0), .checksum(checksum0)
  );

  regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(7)) u1 (
    .clk(clk), .clrn(clrn), .start(start1), .abort(abort1), .rf_rn(rf_rn1), .rf_q(rf_q1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_idx(out_idx1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1), .done(done1), .checksum(checksum1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!clrn) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) chk("hold_stable0", 64'({out_valid0, out_idx0, out_data0, out_last0}), 64'(held0));
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) begin
          chk("unexpected_beat0", 64'({out_idx0, out_data0, out_last0}), 64'(0));
        end else begin
          e0 = q0.pop_front();
          chk("beat0", 64'({out_idx0, out_data0, out_last0}), 64'(e0));
        end
      end
      hold0 = out_valid0 && !out_ready0 && !abort0;
      held0 = {out_valid0, out_idx0, out_data0, out_last0};
      if (done0) begin
        done_cnt0++;
        done_cyc0 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (clrn) begin
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          chk("unexpected_beat1", 64'({out_idx1, out_data1, out_last1}), 64'(0));
        end else begin
          e1 = q1.pop_front();
          chk("beat1", 64'({out_idx1, out_data1, out_last1}), 64'(e1));
        end
      end
      if (done1) begin
        done_cnt1++;
        done_cyc1 = cyc;
      end
    end
  end

  task automatic push0(input int n, input bit wr4);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.idx  = 5'(i);
      b.data = (wr4 && i == 4) ? 32'hDEADBEEF : 32'(i) * 32'h01010101;
      b.last = (i == 31);
      q0.push_back(b);
    end
  endtask

  // Full 0..31 dump on u0; optional ready toggling, mid-dump write of r4, and a stray start.
  task automatic run_dump0(input bit toggle, input bit wr4, input bit restart, input logic [31:0] exp_sum);
    int d0, s, k;
    d0 = done_cnt0;
    k  = 0;
    push0(32, wr4);
    out_ready0 = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    s = cyc;
    chk("cksum_cleared", 64'(checksum0), 64'(0));
    chk("busy_at_start", 64'(busy0), 64'(1));
    while (done_cnt0 == d0 && k < 400) begin
      if (toggle) out_ready0 = (k % 4 == 0) || (k % 4 == 3);
      start0 = restart && (k == 10);
      if (wr4 && k == 7) begin
        @(negedge clk);
        rf[4] = 32'hDEADBEEF;
      end
      step();
      k++;
    end
    start0 = 1'b0;
    chk("done_seen", 64'(done_cnt0 != d0), 64'(1));
    if (!toggle) chk("done_latency", 64'(done_cyc0 - s), 64'(64));
    repeat (3) step();
    chk("done_once", 64'(done_cnt0 - d0), 64'(1));
    chk("checksum_final", 64'(checksum0), 64'(exp_sum));
    chk("queue_drained", 64'(q0.size()), 64'(0));
    chk("busy_after", 64'(busy0), 64'(0));
    out_ready0 = 1'b1;
    if (wr4) rf[4] = 32'h04040404;
  endtask

  initial begin
    int k, d0, s;
    beat_t b;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    clrn = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; out_ready0 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
    #12;
    chk("rst_rf_rn0", 64'(rf_rn0), 64'(0));
    chk("rst_rf_rn1", 64'(rf_rn1), 64'(5));
    chk("rst_outs0", 64'({out_valid0, out_idx0, out_data0, out_last0}), 64'(0));
    chk("rst_busy_done0", 64'({busy0, done0}), 64'(0));
    chk("rst_checksum0", 64'(checksum0), 64'(0));
    @(posedge clk); #1;
    clrn = 1'b1;
    step();

    // Byte lanes each sum to 0x1F0; the carries ripple upward giving F1F1F1F0.
    run_dump0(1'b0, 1'b0, 1'b0, 32'hF1F1F1F0);
    run_dump0(1'b1, 1'b0, 1'b0, 32'hF1F1F1F0);

    // Abort while idx 3 is waiting in SEND; only beats 0..2 are accepted.
    push0(3, 1'b0);
    d0 = done_cnt0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    k = 0;
    while (!(out_valid0 && out_idx0 == 5'd3) && k < 50) begin
      step();
      k++;
    end
    chk("abort_reach_idx3", 64'(out_valid0 && out_idx0 == 5'd3), 64'(1));
    out_ready0 = 1'b0;
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    out_ready0 = 1'b1;
    chk("abort_valid", 64'(out_valid0), 64'(0));
    chk("abort_busy", 64'(busy0), 64'(0));
    repeat (3) step();
    chk("abort_no_done", 64'(done_cnt0 - d0), 64'(0));
    chk("abort_checksum", 64'(checksum0), 64'(32'h06060606));
    chk("abort_queue", 64'(q0.size()), 64'(0));

    // Restart after abort with r4 rewritten just before its READ cycle.
    run_dump0(1'b0, 1'b1, 1'b0, 32'hCC9BACDB);
    // Stray start mid-dump must not restart the walk.
    run_dump0(1'b0, 1'b0, 1'b1, 32'hF1F1F1F0);

    start0 = 1'b1;
    abort0 = 1'b1;
    step();
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("start_abort_busy", 64'(busy0), 64'(0));
    step();
    chk("start_abort_busy2", 64'(busy0), 64'(0));

    // Reset mid-dump while idx 5 is held; beats 0..4 already accepted.
    push0(5, 1'b0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    k = 0;
    while (!(out_valid0 && out_idx0 == 5'd5) && k < 50) begin
      step();
      k++;
    end
    out_ready0 = 1'b0;
    chk("pre_rst_checksum", 64'(checksum0), 64'(32'h0F0F0F0F));
    #1;
    clrn = 1'b0;
    #1;
    chk("midrst_outs", 64'({out_valid0, out_idx0, out_data0, out_last0}), 64'(0));
    chk("midrst_state", 64'({busy0, done0, rf_rn0}), 64'(0));
    chk("midrst_checksum", 64'(checksum0), 64'(0));
    @(posedge clk); #1;
    clrn = 1'b1;
    out_ready0 = 1'b1;
    step();
    chk("midrst_queue", 64'(q0.size()), 64'(0));
    run_dump0(1'b0, 1'b0, 1'b0, 32'hF1F1F1F0);

    // Narrow window 5..7 on u1: 0xFFFFFFFF + 2 + 3 wraps to 4.
    rf[5] = 32'hFFFFFFFF;
    rf[6] = 32'd2;
    rf[7] = 32'd3;
    b = '{idx: 5'd5, data: 32'hFFFFFFFF, last: 1'b0}; q1.push_back(b);
    b = '{idx: 5'd6, data: 32'd2,        last: 1'b0}; q1.push_back(b);
    b = '{idx: 5'd7, data: 32'd3,        last: 1'b1}; q1.push_back(b);
    d0 = done_cnt1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    s = cyc;
    k = 0;
    while (done_cnt1 == d0 && k < 50) begin
      step();
      k++;
    end
    chk("u1_done_seen", 64'(done_cnt1 - d0), 64'(1));
    chk("u1_done_latency", 64'(done_cyc1 - s), 64'(6));
    step();
    chk("u1_checksum", 64'(checksum1), 64'(4));
    chk("u1_queue", 64'(q1.size()), 64'(0));
    chk("u1_busy", 64'(busy1), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
